wptr_full: RTL and testbench

- Write-side pointer and full-flag logic for the dual-clock FIFO; mirror of the read-pointer/empty block.
- Owns the binary write counter, the Gray-coded write pointer (sent to the read domain), the memory write address/enable, and the full, almost-full, level and overflow status.
- Consumes the read pointer already synchronized into the write clock domain (r2w_ptr).
- Sits between the FIFO write client, the dual-port RAM write port, and the write-to-read pointer synchronizer.

---
 rtl/wptr_full_pkg.sv | 28 ++
 rtl/wptr_full_gray2bin.sv | 17 +
 rtl/wptr_full.sv | 85 ++++++++
 tb/tb_wptr_full.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wptr_full_pkg.sv
// Shared dual-clock FIFO definitions: default geometry and Gray-code helpers
// used by both the write-pointer/full and read-pointer/empty blocks.
package wptr_full_pkg;

  localparam int unsigned DSIZE_DEF       = 8;
  localparam int unsigned ASIZE_DEF       = 4;
  localparam int unsigned DEPTH_DEF       = 1 << ASIZE_DEF;
  localparam int unsigned AFULL_LEVEL_DEF = 12;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pointer value the write side reaches when it is one full lap ahead of g.
  function automatic logic [31:0] full_cmp(input logic [31:0] g, input int unsigned asize);
    return g ^ (32'h3 << (asize - 1));
  endfunction

endpackage

// File: rtl/wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o      = '0;
    bin_o[W-1] = gray_i[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer, full, almost-full, level and sticky-overflow logic of the
// dual-clock FIFO. Only wr_ptr (registered Gray) crosses into the read domain.
module wptr_full
  import wptr_full_pkg::bin2gray;
  import wptr_full_pkg::full_cmp;
  import wptr_full_pkg::DSIZE_DEF;
  import wptr_full_pkg::ASIZE_DEF;
  import wptr_full_pkg::AFULL_LEVEL_DEF;
#(
  parameter int unsigned DSIZE       = DSIZE_DEF,
  parameter int unsigned ASIZE       = ASIZE_DEF,
  parameter int unsigned AFULL_LEVEL = AFULL_LEVEL_DEF
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  input  logic             wr_inc,
  input  logic [ASIZE:0]   r2w_ptr,
  input  logic             wr_ovf_clr,
  output logic [ASIZE:0]   wr_ptr,
  output logic [ASIZE-1:0] wr_addr,
  output logic             wr_mem_en,
  output logic             wr_full,
  output logic             wr_almost_full,
  output logic [ASIZE:0]   wr_level,
  output logic             wr_overflow
);

  localparam int unsigned PW    = ASIZE + 1;
  localparam int unsigned DEPTH = 1 << ASIZE;

  if (DSIZE < 1 || AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_param_check
    $error("wptr_full: illegal DSIZE/AFULL_LEVEL for this ASIZE");
  end

  logic [ASIZE:0] wbin_q, wbin_d;
  logic [ASIZE:0] wr_ptr_q, wr_ptr_d;
  logic [ASIZE:0] wr_level_q, wr_level_d;
  logic           wr_full_q, wr_full_d;
  logic           wr_almost_full_q, wr_almost_full_d;
  logic           wr_overflow_q, wr_overflow_d;
  logic [ASIZE:0] rbin_s;

  gray2bin #(.W(PW)) u_r2w_g2b (
    .gray_i (r2w_ptr),
    .bin_o  (rbin_s)
  );

  // A write is accepted only while not full; a refused write is what flags overflow.
  assign wr_mem_en = wr_inc & ~wr_full_q;

  always_comb begin
    wbin_d           = wbin_q + PW'(wr_mem_en);
    wr_ptr_d         = PW'(bin2gray(32'(wbin_d)));
    wr_full_d        = (wr_ptr_d == PW'(full_cmp(32'(r2w_ptr), ASIZE)));
    wr_level_d       = wbin_d - rbin_s;
    wr_almost_full_d = (32'(wr_level_d) >= AFULL_LEVEL);
    wr_overflow_d    = (wr_inc & wr_full_q) | (wr_overflow_q & ~wr_ovf_clr);
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      wbin_q           <= '0;
      wr_ptr_q         <= '0;
      wr_full_q        <= 1'b0;
      wr_almost_full_q <= 1'b0;
      wr_level_q       <= '0;
      wr_overflow_q    <= 1'b0;
    end else begin
      wbin_q           <= wbin_d;
      wr_ptr_q         <= wr_ptr_d;
      wr_full_q        <= wr_full_d;
      wr_almost_full_q <= wr_almost_full_d;
      wr_level_q       <= wr_level_d;
      wr_overflow_q    <= wr_overflow_d;
    end
  end

  assign wr_ptr         = wr_ptr_q;
  assign wr_addr        = wbin_q[ASIZE-1:0];
  assign wr_full        = wr_full_q;
  assign wr_almost_full = wr_almost_full_q;
  assign wr_level       = wr_level_q;
  assign wr_overflow    = wr_overflow_q;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: directed scenarios plus randomized traffic
// against an occupancy-count model (writes accepted vs. reads seen).
module tb_wptr_full;

  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       wr_clk = 1'b0;
  logic       wr_rst_n;
  logic       wr_inc;
  logic [4:0] r2w_ptr;
  logic       wr_ovf_clr;
  logic [4:0] wr_ptr;
  logic [3:0] wr_addr;
  logic       wr_mem_en;
  logic       wr_full;
  logic       wr_almost_full;
  logic [4:0] wr_level;
  logic       wr_overflow;

  wptr_full #(.DSIZE(8), .ASIZE(ASIZE), .AFULL_LEVEL(AFULL)) dut (
    .wr_clk         (wr_clk),
    .wr_rst_n       (wr_rst_n),
    .wr_inc         (wr_inc),
    .r2w_ptr        (r2w_ptr),
    .wr_ovf_clr     (wr_ovf_clr),
    .wr_ptr         (wr_ptr),
    .wr_addr        (wr_addr),
    .wr_mem_en      (wr_mem_en),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: total writes accepted, total reads visible to the write side.
  int m_w = 0;
  int m_r = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;
  int m_level = 0;

  logic       obs_mem_en, exp_mem_en;
  logic [3:0] obs_addr, exp_addr;

  function automatic logic [4:0] gray_of(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  // {wr_ptr, wr_addr, wr_full, wr_almost_full, wr_level, wr_overflow}
  function automatic logic [16:0] exp_vec();
    return {gray_of(m_w), 4'(m_w % DEPTH), m_full, m_afull, 5'(m_level), m_ovf};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {wr_ptr, wr_addr, wr_full, wr_almost_full, wr_level, wr_overflow};
  endfunction

  // Applies one cycle of stimulus, captures mid-cycle combinational outputs, advances the model.
  task automatic step(input bit inc, input bit clr, input bit rst_n);
    bit acc;
    wr_inc     = inc;
    wr_ovf_clr = clr;
    wr_rst_n   = rst_n;
    r2w_ptr    = gray_of(m_r);
    #2;
    obs_mem_en = wr_mem_en;
    obs_addr   = wr_addr;
    exp_mem_en = inc & ~m_full;
    exp_addr   = 4'(m_w % DEPTH);
    @(posedge wr_clk);
    if (!rst_n) begin
      m_w = 0; m_full = 0; m_afull = 0; m_level = 0; m_ovf = 0;
    end else begin
      acc     = inc && !m_full;
      m_ovf   = (inc && m_full) || (m_ovf && !clr);
      m_w     = m_w + int'(acc);
      m_level = m_w - m_r;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= AFULL);
    end
    #1;
  endtask

  task automatic test_reset();
    m_r = 0;
    step(1, 0, 0);
    step(1, 0, 0);
    n_checks++;
    if (dut_vec() !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), 17'h0);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, 1);
      n_checks++;
      if (obs_mem_en !== 1'b1 || obs_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL fill_mem_port[%0d]: got en=%b addr=%0d expected en=1 addr=%0d",
                 i, obs_mem_en, obs_addr, exp_addr);
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_state[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (wr_ptr !== 5'b11000 || wr_full !== 1'b1 || wr_level !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_final: got ptr=%b full=%b level=%0d expected ptr=11000 full=1 level=16",
               wr_ptr, wr_full, wr_level);
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 1);
    n_checks++;
    if (obs_mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_mem_en: got %b expected 0", obs_mem_en);
    end
    n_checks++;
    if (wr_ptr !== 5'b11000 || wr_overflow !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_set: got %h expected %h", dut_vec(), exp_vec());
    end
    step(0, 1, 1);
    n_checks++;
    if (wr_overflow !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_clear: got %h expected %h", dut_vec(), exp_vec());
    end
    // Set beats clear when both land in the same cycle.
    step(1, 1, 1);
    n_checks++;
    if (wr_overflow !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %h expected %h", dut_vec(), exp_vec());
    end
    step(0, 1, 1);
  endtask

  task automatic test_drain();
    m_r = 4;
    step(0, 0, 1);
    n_checks++;
    if (wr_full !== 1'b0 || wr_level !== 5'd12 || wr_almost_full !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_r4: got full=%b level=%0d afull=%b expected full=0 level=12 afull=1",
               wr_full, wr_level, wr_almost_full);
    end
    m_r = 5;
    step(0, 0, 1);
    n_checks++;
    if (wr_level !== 5'd11 || wr_almost_full !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL drain_r5: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    bit saw_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      prev = wr_ptr;
      m_r  = m_w;
      step(1, 0, 1);
      if (prev == 5'b10000 && wr_ptr == 5'b00000) saw_wrap = 1;
      n_checks++;
      if ($countones(prev ^ wr_ptr) != 1) begin
        n_fail++;
        $display("FAIL wrap_one_bit[%0d]: got %b -> %b expected one toggled bit", i, prev, wr_ptr);
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_state[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (!saw_wrap) begin
      n_fail++;
      $display("FAIL wrap_seen: got no 10000->00000 transition expected one");
    end
  endtask

  task automatic test_random();
    bit inc, clr;
    for (int i = 0; i < 400; i++) begin
      inc = ($urandom_range(3) != 0);
      clr = ($urandom_range(7) == 0);
      if (m_r < m_w && $urandom_range(2) == 0) m_r = m_r + 1;
      step(inc, clr, 1);
      n_checks++;
      if (obs_mem_en !== exp_mem_en || obs_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL rand_mem_port[%0d]: got en=%b addr=%0d expected en=%b addr=%0d",
                 i, obs_mem_en, obs_addr, exp_mem_en, exp_addr);
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 20 && !m_full; i++) step(1, 0, 1);
    n_checks++;
    if (wr_full !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL midrst_prefull: got %h expected %h", dut_vec(), exp_vec());
    end
    m_r = 0;
    step(1, 0, 0);
    n_checks++;
    if (dut_vec() !== 17'h0) begin
      n_fail++;
      $display("FAIL midrst_clear: got %h expected %h", dut_vec(), 17'h0);
    end
    step(1, 0, 1);
    n_checks++;
    if (obs_addr !== 4'd0 || wr_addr !== 4'd1 || wr_ptr !== 5'b00001 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL midrst_write: got addr %0d->%0d ptr=%b expected addr 0->1 ptr=00001",
               obs_addr, wr_addr, wr_ptr);
    end
  endtask

  initial begin
    wr_inc = 0; wr_ovf_clr = 0; wr_rst_n = 0; r2w_ptr = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_random();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
